// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared FSM states, speed and mode constants for the audio sequencer
package aud_pkg;

    // Values are visible on o_state for the front-panel LEDs, so keep them fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_STOP  = 3'd2,
        ST_DSP   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_PAUSE = 3'd5
    } aud_state_e;

    localparam int   SPD_NORM  = 7;     // 1x playback speed code
    localparam int   SPD_MAX   = 14;    // fastest speed code
    localparam logic MODE_PLAY = 1'b0;
    localparam logic MODE_REC  = 1'b1;

endpackage

// File: rtl/aud_speed_ctr.sv
// rtl/aud_speed_ctr.sv - saturating speed code counter driven by up/down key pulses
// Ports: i_clk, i_rst_n (async active-low), i_up / i_down key pulses,
//        o_speed current speed code (0..SPD_MAX, resets to SPD_NORM).
module aud_speed_ctr #(
    parameter int SPD_MAX  = aud_pkg::SPD_MAX,
    parameter int SPD_NORM = aud_pkg::SPD_NORM
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_up,
    input  logic       i_down,
    output logic [3:0] o_speed
);

    logic [3:0] r_speed;

    // Simultaneous up and down cancel out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_speed <= 4'(SPD_NORM);
        end else if (i_up && !i_down && (r_speed != 4'(SPD_MAX))) begin
            r_speed <= r_speed + 4'd1;
        end else if (i_down && !i_up && (r_speed != 4'd0)) begin
            r_speed <= r_speed - 4'd1;
        end
    end

    assign o_speed = r_speed;

endmodule

// File: rtl/aud_seq_ctrl.sv
// rtl/aud_seq_ctrl.sv - audio record/play frame sequencer (codec init, per-channel DSP and I2S handshakes)
// Ports: i_clk, i_rst_n (async active-low); i_mode/i_interpol run settings latched on start;
//        i_key_start/stop/up/down key pulses; i_init_fin, i_dsp_fin, i_io_fin completion strobes;
//        i_addr current DSP address. o_init_start/o_dsp_clear levels; o_dsp_start,
//        o_play_start, o_rec_start registered single-cycle pulses; o_ch serviced channel;
//        o_mode/o_interpol latched settings; o_speed speed code; o_rec_end last recorded
//        address; o_state FSM state for LEDs.
module aud_seq_ctrl #(
    parameter int NCH      = 2,
    parameter int AW       = 20,
    parameter int SPD_MAX  = aud_pkg::SPD_MAX,
    parameter int SPD_NORM = aud_pkg::SPD_NORM,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_mode,
    input  logic           i_interpol,
    input  logic           i_key_start,
    input  logic           i_key_stop,
    input  logic           i_key_up,
    input  logic           i_key_down,
    input  logic           i_init_fin,
    input  logic           i_dsp_fin,
    input  logic           i_io_fin,
    input  logic [AW-1:0]  i_addr,
    output logic           o_init_start,
    output logic           o_dsp_clear,
    output logic           o_dsp_start,
    output logic           o_play_start,
    output logic           o_rec_start,
    output logic [CHW-1:0] o_ch,
    output logic           o_mode,
    output logic           o_interpol,
    output logic [3:0]     o_speed,
    output logic [AW-1:0]  o_rec_end,
    output logic [2:0]     o_state
);

    aud_pkg::aud_state_e r_state, w_next_state;

    logic [CHW-1:0] r_ch, w_ch_nxt;
    logic           r_init_start, r_dsp_clear;
    logic           r_dsp_start, w_dsp_start_nxt;
    logic           r_play_start, w_play_start_nxt;
    logic           r_rec_start, w_rec_start_nxt;
    logic           r_stop_req, w_stop_req_nxt;
    logic           r_pause_req, w_pause_req_nxt;
    logic           r_mode, w_mode_nxt;
    logic           r_interpol, w_interpol_nxt;
    logic [AW-1:0]  r_rec_end, w_rec_end_nxt;

    logic w_limit, w_stop_any, w_pause_any, w_last_ch;

    // Record stops when memory is full; play stops once it reaches the recorded end.
    assign w_limit     = (r_mode == aud_pkg::MODE_REC) ? (i_addr == {AW{1'b1}})
                                                       : (i_addr >= r_rec_end);
    // A key pressed in the very cycle the frame ends still counts for that frame end.
    assign w_stop_any  = r_stop_req  | i_key_stop;
    assign w_pause_any = r_pause_req | i_key_start;
    assign w_last_ch   = (r_ch == CHW'(NCH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= aud_pkg::ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_ch_nxt         = r_ch;
        w_dsp_start_nxt  = 1'b0;
        w_play_start_nxt = 1'b0;
        w_rec_start_nxt  = 1'b0;
        w_stop_req_nxt   = r_stop_req;
        w_pause_req_nxt  = r_pause_req;
        w_mode_nxt       = r_mode;
        w_interpol_nxt   = r_interpol;
        w_rec_end_nxt    = r_rec_end;

        case (r_state)
            aud_pkg::ST_IDLE: begin
                w_next_state = aud_pkg::ST_INIT;
            end
            aud_pkg::ST_INIT: begin
                if (i_init_fin) begin
                    w_next_state = aud_pkg::ST_STOP;
                    w_ch_nxt     = '0;
                end
            end
            aud_pkg::ST_STOP: begin
                w_ch_nxt = '0;
                if (i_key_start) begin
                    w_mode_nxt      = i_mode;
                    w_interpol_nxt  = i_interpol;
                    w_dsp_start_nxt = 1'b1;
                    w_next_state    = aud_pkg::ST_DSP;
                end
            end
            aud_pkg::ST_DSP: begin
                w_stop_req_nxt  = w_stop_any;
                w_pause_req_nxt = w_pause_any;
                if (i_dsp_fin) begin
                    w_rec_start_nxt  = (r_mode == aud_pkg::MODE_REC);
                    w_play_start_nxt = (r_mode == aud_pkg::MODE_PLAY);
                    w_next_state     = aud_pkg::ST_WAIT;
                end
            end
            aud_pkg::ST_WAIT: begin
                w_stop_req_nxt  = w_stop_any;
                w_pause_req_nxt = w_pause_any;
                if (i_io_fin) begin
                    if (!w_last_ch) begin
                        w_ch_nxt        = r_ch + CHW'(1);
                        w_dsp_start_nxt = 1'b1;
                        w_next_state    = aud_pkg::ST_DSP;
                    end else begin
                        // Frame boundary: the only place a run may stop or pause.
                        w_stop_req_nxt  = 1'b0;
                        w_pause_req_nxt = 1'b0;
                        w_ch_nxt        = '0;
                        if (w_stop_any || w_limit) begin
                            w_next_state = aud_pkg::ST_STOP;
                            if (r_mode == aud_pkg::MODE_REC) begin
                                w_rec_end_nxt = i_addr;
                            end
                        end else if (w_pause_any) begin
                            w_next_state = aud_pkg::ST_PAUSE;
                        end else begin
                            w_dsp_start_nxt = 1'b1;
                            w_next_state    = aud_pkg::ST_DSP;
                        end
                    end
                end
            end
            aud_pkg::ST_PAUSE: begin
                if (i_key_stop) begin
                    w_next_state = aud_pkg::ST_STOP;
                    w_ch_nxt     = '0;
                    if (r_mode == aud_pkg::MODE_REC) begin
                        w_rec_end_nxt = i_addr;
                    end
                end else if (i_key_start) begin
                    w_ch_nxt        = '0;
                    w_dsp_start_nxt = 1'b1;
                    w_next_state    = aud_pkg::ST_DSP;
                end
            end
            default: begin
                w_next_state = aud_pkg::ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ch         <= '0;
            r_init_start <= 1'b0;
            r_dsp_clear  <= 1'b0;
            r_dsp_start  <= 1'b0;
            r_play_start <= 1'b0;
            r_rec_start  <= 1'b0;
            r_stop_req   <= 1'b0;
            r_pause_req  <= 1'b0;
            r_mode       <= aud_pkg::MODE_REC;
            r_interpol   <= 1'b0;
            r_rec_end    <= {AW{1'b1}};
        end else begin
            r_ch         <= w_ch_nxt;
            // Levels follow the next state so they line up with o_state.
            r_init_start <= (w_next_state == aud_pkg::ST_INIT);
            r_dsp_clear  <= (w_next_state == aud_pkg::ST_STOP);
            r_dsp_start  <= w_dsp_start_nxt;
            r_play_start <= w_play_start_nxt;
            r_rec_start  <= w_rec_start_nxt;
            r_stop_req   <= w_stop_req_nxt;
            r_pause_req  <= w_pause_req_nxt;
            r_mode       <= w_mode_nxt;
            r_interpol   <= w_interpol_nxt;
            r_rec_end    <= w_rec_end_nxt;
        end
    end

    aud_speed_ctr #(
        .SPD_MAX  (SPD_MAX),
        .SPD_NORM (SPD_NORM)
    ) u_speed (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_up    (i_key_up),
        .i_down  (i_key_down),
        .o_speed (o_speed)
    );

    assign o_init_start = r_init_start;
    assign o_dsp_clear  = r_dsp_clear;
    assign o_dsp_start  = r_dsp_start;
    assign o_play_start = r_play_start;
    assign o_rec_start  = r_rec_start;
    assign o_ch         = r_ch;
    assign o_mode       = r_mode;
    assign o_interpol   = r_interpol;
    assign o_rec_end    = r_rec_end;
    assign o_state      = r_state;

endmodule

// File: tb/tb_aud_seq_ctrl.sv
// tb/tb_aud_seq_ctrl.sv - randomized self-checking bench for aud_seq_ctrl
module tb_aud_seq_ctrl;

    localparam int NCH = 2;
    localparam int AW  = 20;

    localparam logic [2:0] S_IDLE = 3'd0, S_INIT = 3'd1, S_STOP = 3'd2,
                           S_DSP = 3'd3, S_WAIT = 3'd4, S_PAUSE = 3'd5;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_mode = 1'b0, i_interpol = 1'b0;
    logic          i_key_start = 1'b0, i_key_stop = 1'b0, i_key_up = 1'b0, i_key_down = 1'b0;
    logic          i_init_fin = 1'b0, i_dsp_fin = 1'b0, i_io_fin = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          o_init_start, o_dsp_clear, o_dsp_start, o_play_start, o_rec_start;
    logic [0:0]    o_ch;
    logic          o_mode, o_interpol;
    logic [3:0]    o_speed;
    logic [AW-1:0] o_rec_end;
    logic [2:0]    o_state;

    aud_seq_ctrl #(.NCH(NCH), .AW(AW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_interpol(i_interpol),
        .i_key_start(i_key_start), .i_key_stop(i_key_stop), .i_key_up(i_key_up),
        .i_key_down(i_key_down), .i_init_fin(i_init_fin), .i_dsp_fin(i_dsp_fin),
        .i_io_fin(i_io_fin), .i_addr(i_addr), .o_init_start(o_init_start),
        .o_dsp_clear(o_dsp_clear), .o_dsp_start(o_dsp_start), .o_play_start(o_play_start),
        .o_rec_start(o_rec_start), .o_ch(o_ch), .o_mode(o_mode), .o_interpol(o_interpol),
        .o_speed(o_speed), .o_rec_end(o_rec_end), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_dsp    = 0;

    // Reference model state
    logic          m_mode, m_interpol;
    logic [AW-1:0] m_rec_end;
    int            m_speed;

    always @(negedge i_clk) if (o_dsp_start) n_dsp++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic press(input logic st, input logic sp, input logic up, input logic dn);
        i_key_start = st; i_key_stop = sp; i_key_up = up; i_key_down = dn;
        tick;
        i_key_start = 1'b0; i_key_stop = 1'b0; i_key_up = 1'b0; i_key_down = 1'b0;
    endtask

    task automatic wait_dsp_start(input string tag);
        int k = 0;
        while (!o_dsp_start && k < 40) begin
            tick;
            k++;
        end
        check(tag, {31'd0, o_dsp_start}, 32'd1);
    endtask

    task automatic start_run(input logic mode);
        i_mode     = mode;
        i_interpol = 1'($urandom);
        m_mode     = mode;
        m_interpol = i_interpol;
        press(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // One full frame: every channel gets a DSP then an I/O handshake.
    // Keys are optionally pressed while waiting on channel 0's I/O slot.
    task automatic run_frame(input logic exp_rec, input logic key_start_w, input logic key_stop_w);
        for (int c = 0; c < NCH; c++) begin
            wait_dsp_start("dsp_start");
            i_mode     = 1'($urandom);
            i_interpol = 1'($urandom);
            repeat ($urandom_range(0, 3)) tick;
            i_dsp_fin = 1'b1; tick; i_dsp_fin = 1'b0;
            check("io_pulse",    exp_rec ? o_rec_start : o_play_start, 1);
            check("other_pulse", exp_rec ? o_play_start : o_rec_start, 0);
            check("ch",          o_ch, c);
            check("mode_latch",  o_mode, m_mode);
            check("interp_latch", o_interpol, m_interpol);
            if (c == 0 && (key_start_w || key_stop_w)) press(key_start_w, key_stop_w, 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                i_dsp_fin = 1'b1; tick; i_dsp_fin = 1'b0;
                check("stray_dsp_fin", {31'd0, o_rec_start | o_play_start}, 0);
            end
            repeat ($urandom_range(0, 3)) tick;
            i_io_fin = 1'b1; tick; i_io_fin = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic up, dn;

        // Reset values
        #2 i_rst_n = 1'b0;
        tick; tick;
        check("rst_state",    o_state, S_IDLE);
        check("rst_ch",       o_ch, 0);
        check("rst_speed",    o_speed, 7);
        check("rst_mode",     o_mode, 1);
        check("rst_interpol", o_interpol, 0);
        check("rst_rec_end",  o_rec_end, 20'hFFFFF);
        check("rst_pulses",   {29'd0, o_dsp_start, o_play_start, o_rec_start}, 0);
        check("rst_levels",   {30'd0, o_init_start, o_dsp_clear}, 0);
        m_rec_end = 20'hFFFFF;
        m_speed   = 7;

        // Init sequence: init_fin seen in cycle 5
        i_rst_n = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            tick;
            check("init_start_lvl", o_init_start, 1);
            check("init_state", o_state, S_INIT);
            if (cyc == 1) check("no_pulse_after_rst", {29'd0, o_dsp_start, o_play_start, o_rec_start}, 0);
        end
        i_init_fin = 1'b1; tick; i_init_fin = 1'b0;
        check("stop_after_init", o_state, S_STOP);
        check("init_start_off", o_init_start, 0);
        check("dsp_clear_stop", o_dsp_clear, 1);
        check("speed_after_init", o_speed, 7);

        // Record run ends on memory-full limit
        i_addr = AW'($urandom_range(0, 20'hFFFFE));
        start_run(1'b1);
        run_frame(1'b1, 1'b0, 1'b0);
        check("rec_continue", o_state, S_DSP);
        i_addr = 20'hFFFFF;
        run_frame(1'b1, 1'b0, 1'b0);
        m_rec_end = 20'hFFFFF;
        check("rec_limit_stop", o_state, S_STOP);
        check("rec_limit_end",  o_rec_end, m_rec_end);

        // Record run stopped mid-frame: frame completes first
        i_addr = AW'($urandom_range(0, 20'hFFFFE));
        start_run(1'b1);
        repeat ($urandom_range(1, 2)) run_frame(1'b1, 1'b0, 1'b0);
        i_addr = 20'h00100;
        run_frame(1'b1, 1'b0, 1'b1);
        m_rec_end = 20'h00100;
        check("rec_stop_state", o_state, S_STOP);
        check("rec_stop_end",   o_rec_end, m_rec_end);
        check("rec_stop_ch",    o_ch, 0);
        n0 = n_dsp;
        repeat (5) tick;
        check("rec_stop_quiet", n_dsp, n0);

        // Play run ends when address reaches recorded end
        i_addr = 20'h00080;
        start_run(1'b0);
        run_frame(1'b0, 1'b0, 1'b0);
        check("play_continue", o_state, S_DSP);
        i_addr = 20'h00100;
        run_frame(1'b0, 1'b0, 1'b0);
        check("play_limit_stop", o_state, S_STOP);
        check("play_rec_end",    o_rec_end, m_rec_end);
        n0 = n_dsp;
        repeat (10) tick;
        check("play_no_dsp", n_dsp, n0);

        // Pause at frame end, resume, pause again, start+stop -> STOP
        i_addr = 20'h00010;
        start_run(1'b0);
        run_frame(1'b0, 1'b1, 1'b0);
        check("pause_state", o_state, S_PAUSE);
        n0 = n_dsp;
        repeat (5) tick;
        check("pause_quiet", n_dsp, n0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("resume_ch", o_ch, 0);
        run_frame(1'b0, 1'b1, 1'b0);
        check("pause_again", o_state, S_PAUSE);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check("pause_both_stop", o_state, S_STOP);
        check("pause_rec_end",   o_rec_end, m_rec_end);

        // Speed counter
        for (int i = 0; i < 15; i++) begin
            press(1'b0, 1'b0, 1'b1, 1'b0);
            if (m_speed < 14) m_speed++;
        end
        check("speed_max", o_speed, m_speed);
        press(1'b0, 1'b0, 1'b1, 1'b1);
        check("speed_both", o_speed, m_speed);
        for (int i = 0; i < 20; i++) begin
            press(1'b0, 1'b0, 1'b0, 1'b1);
            if (m_speed > 0) m_speed--;
        end
        check("speed_min", o_speed, m_speed);
        for (int i = 0; i < 40; i++) begin
            up = 1'($urandom);
            dn = 1'($urandom);
            press(1'b0, 1'b0, up, dn);
            if (up && !dn && m_speed < 14) m_speed++;
            else if (dn && !up && m_speed > 0) m_speed--;
            check("speed_rand", o_speed, m_speed);
        end

        // Reset in the middle of a run
        i_addr = AW'($urandom_range(0, 20'hFFFFE));
        start_run(1'b1);
        wait_dsp_start("mid_dsp_start");
        i_dsp_fin = 1'b1; tick; i_dsp_fin = 1'b0;
        check("mid_wait", o_state, S_WAIT);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_state",   o_state, S_IDLE);
        check("mid_rst_ch",      o_ch, 0);
        check("mid_rst_speed",   o_speed, 7);
        check("mid_rst_rec_end", o_rec_end, 20'hFFFFF);
        check("mid_rst_pulses",  {29'd0, o_dsp_start, o_play_start, o_rec_start}, 0);
        tick;
        i_rst_n = 1'b1;
        tick;
        check("mid_rel_state",  o_state, S_INIT);
        check("mid_rel_pulses", {29'd0, o_dsp_start, o_play_start, o_rec_start}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
